// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Lengths beyond the history depth collapse to the full history.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_match.sv
// Combinational masked compare of the low `len` history bits against a pattern.
module seq_match
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] hist,
    input  logic [LEN_W-1:0]   fill,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] diff;

    // Only bit positions below len take part in the compare.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_bit
        assign diff[gi] = (hist[gi] ^ pattern[gi]) & (gi < int'(len));
    end

    assign hit = (len != '0) && (fill >= len) && (diff == '0);

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with a sticky lock-out pattern.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_lock_en,
    input  logic [MAX_LEN-1:0] cfg_lock_pattern,
    input  logic [LEN_W-1:0]   cfg_lock_len,
    output logic               detect,
    output logic               locked,
    output logic [CNT_W-1:0]   match_count
);

    state_t             state_reg, state_next;
    logic [MAX_LEN-1:0] hist_reg, nxt_hist;
    logic [LEN_W-1:0]   fill_reg, nxt_fill;
    logic [MAX_LEN-1:0] pattern_reg, lock_pattern_reg;
    logic [LEN_W-1:0]   len_reg, lock_len_reg;
    logic               overlap_reg, lock_en_reg;
    logic               detect_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               pat_hit, lock_raw, lock_hit, shift_en;

    assign nxt_hist = {hist_reg[MAX_LEN-2:0], in};
    assign nxt_fill = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + 1'b1;
    // A cfg write takes the cycle; its accompanying data bit is dropped.
    assign shift_en = (state_reg == HUNT) && in_valid && !cfg_we;

    seq_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_pat_match (
        .hist    (nxt_hist),
        .fill    (nxt_fill),
        .pattern (pattern_reg),
        .len     (len_reg),
        .hit     (pat_hit)
    );

    seq_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_lock_match (
        .hist    (nxt_hist),
        .fill    (nxt_fill),
        .pattern (lock_pattern_reg),
        .len     (lock_len_reg),
        .hit     (lock_raw)
    );

    assign lock_hit = lock_raw && lock_en_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (shift_en && lock_hit) begin
            state_next = LOCKED;
        end
    end

    always_comb begin
        detect      = detect_reg;
        locked      = (state_reg == LOCKED);
        match_count = count_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg         <= '0;
            fill_reg         <= '0;
            pattern_reg      <= '0;
            len_reg          <= '0;
            overlap_reg      <= 1'b0;
            lock_en_reg      <= 1'b0;
            lock_pattern_reg <= '0;
            lock_len_reg     <= '0;
            detect_reg       <= 1'b0;
            count_reg        <= '0;
        end else begin
            detect_reg <= 1'b0;
            if (state_reg == HUNT && cfg_we) begin
                pattern_reg      <= cfg_pattern;
                len_reg          <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
                overlap_reg      <= cfg_overlap;
                lock_en_reg      <= cfg_lock_en;
                lock_pattern_reg <= cfg_lock_pattern;
                lock_len_reg     <= LEN_W'(clamp_len(int'(cfg_lock_len), MAX_LEN));
                hist_reg         <= '0;
                fill_reg         <= '0;
                count_reg        <= '0;
            end else if (shift_en) begin
                hist_reg <= nxt_hist;
                fill_reg <= nxt_fill;
                // Lock-out takes precedence over a simultaneous pattern hit.
                if (!lock_hit && pat_hit) begin
                    detect_reg <= 1'b1;
                    count_reg  <= (&count_reg) ? count_reg : count_reg + 1'b1;
                    if (!overlap_reg) begin
                        fill_reg <= '0;
                    end
                end
            end
        end
    end

`ifdef ASSERTIONS
    a_known: assert property (@(posedge clk) !rst |-> !$isunknown({state_reg, detect_reg, count_reg}));
    a_rst:   assert property (@(posedge clk) rst |=> (state_reg == HUNT && count_reg == '0));
    a_lock:  assert property (@(posedge clk) (state_reg == LOCKED && !rst) |=> state_reg == LOCKED);
    a_det:   assert property (@(posedge clk) detect_reg |-> !locked);
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench for seq_detector_param with a queue-based scoreboard.
module tb_seq_detector_param;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in = 1'b0;
    logic               in_valid = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cfg_lock_en = 1'b0;
    logic [MAX_LEN-1:0] cfg_lock_pattern = '0;
    logic [LEN_W-1:0]   cfg_lock_len = '0;
    logic               detect;
    logic               locked;
    logic [CNT_W-1:0]   match_count;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in               (in),
        .in_valid         (in_valid),
        .cfg_we           (cfg_we),
        .cfg_pattern      (cfg_pattern),
        .cfg_len          (cfg_len),
        .cfg_overlap      (cfg_overlap),
        .cfg_lock_en      (cfg_lock_en),
        .cfg_lock_pattern (cfg_lock_pattern),
        .cfg_lock_len     (cfg_lock_len),
        .detect           (detect),
        .locked           (locked),
        .match_count      (match_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             det;
        logic             lk;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    passed = 0;
    int    total  = 0;

    task automatic expect_out(input logic ed, input logic el, input int ec, input string nm);
        exp_t e;
        e.det = ed;
        e.lk  = el;
        e.cnt = CNT_W'(ec);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        expect_out(1'b0, 1'b0, 0, nm);
    endtask

    // The cfg cycle also presents a valid 1 that must be discarded.
    task automatic do_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic ov, input logic len_en,
                          input logic [MAX_LEN-1:0] lpat, input logic [LEN_W-1:0] llen,
                          input logic el, input int ec, input string nm);
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b1; in = 1'b1; in_valid = 1'b1;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        cfg_lock_en = len_en; cfg_lock_pattern = lpat; cfg_lock_len = llen;
        @(posedge clk);
        expect_out(1'b0, el, ec, nm);
    endtask

    task automatic step(input logic b, input logic v, input logic ed, input logic el,
                        input int ec, input string nm);
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b0; in = b; in_valid = v;
        @(posedge clk);
        expect_out(ed, el, ec, nm);
    endtask

    // Monitor: one registered response per clock, checked 1 time unit after the edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                total++;
                if (detect !== e.det || locked !== e.lk || match_count !== e.cnt) begin
                    $display("FAIL %s: got det=%b locked=%b cnt=%0d, expected det=%b locked=%b cnt=%0d",
                             nm, detect, locked, match_count, e.det, e.lk, e.cnt);
                end else begin
                    passed++;
                    $display("ok   %s: det=%b locked=%b cnt=%0d", nm, detect, locked, match_count);
                end
            end
        end
    end

    initial begin
        logic [15:0] vec_ov;
        logic [15:0] vec_big;
        int          cnt;
        vec_ov  = 16'b0000_0000_0101_1011; // low 7 bits: stream 1,0,1,1,0,1,1
        vec_big = 16'hA5C3;

        do_reset("reset");

        // Overlapping 1011 over 1011011: hits after bits 4 and 7.
        do_cfg(16'b1011, 5'd4, 1'b1, 1'b0, '0, '0, 1'b0, 0, "cfg_ov1");
        for (int i = 6; i >= 0; i--) begin
            cnt = (i <= 0) ? 2 : ((i <= 3) ? 1 : 0);
            step(vec_ov[i], 1'b1, (i == 3 || i == 0), 1'b0, cnt, $sformatf("ov1_bit%0d", 7 - i));
        end

        // Non-overlapping: cfg clears the count; only the first hit survives.
        do_cfg(16'b1011, 5'd4, 1'b0, 1'b0, '0, '0, 1'b0, 0, "cfg_ov0");
        for (int i = 6; i >= 0; i--) begin
            step(vec_ov[i], 1'b1, (i == 3), 1'b0, (i <= 3) ? 1 : 0, $sformatf("ov0_bit%0d", 7 - i));
        end

        // Gaps inside the pattern must not shift anything in.
        do_cfg(16'b1011, 5'd4, 1'b1, 1'b0, '0, '0, 1'b0, 0, "cfg_gap");
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, "gap_b1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "gap_b2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, "gap_idle1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, "gap_idle2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "gap_idle3");
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, "gap_b3");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1, "gap_b4");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1, "gap_after");

        // Lock pattern present but disabled: 0001 detects normally.
        do_cfg(16'b0001, 5'd4, 1'b0, 1'b0, 16'b000, 5'd3, 1'b0, 0, "cfg_lockoff");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "lockoff_b1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "lockoff_b2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "lockoff_b3");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1, "lockoff_b4");

        // Lock-out enabled: 000 locks after the third bit.
        do_cfg(16'b0001, 5'd4, 1'b0, 1'b1, 16'b000, 5'd3, 1'b0, 0, "cfg_lockon");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "lock_b1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "lock_b2");
        step(1'b0, 1'b1, 1'b0, 1'b1, 0, "lock_b3");
        step(1'b1, 1'b1, 1'b0, 1'b1, 0, "lock_b4_ignored");
        do_cfg(16'b1, 5'd1, 1'b1, 1'b0, '0, '0, 1'b1, 0, "lock_cfg_ignored");
        step(1'b1, 1'b1, 1'b0, 1'b1, 0, "lock_bit_ignored");
        do_reset("lock_reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, "post_reset_cfg_cleared");

        // Pattern and lock both 000: lock wins, no detect.
        do_cfg(16'b000, 5'd3, 1'b1, 1'b1, 16'b000, 5'd3, 1'b0, 0, "cfg_both");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "both_b1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "both_b2");
        step(1'b0, 1'b1, 1'b0, 1'b1, 0, "both_b3");
        do_reset("both_reset");

        // Single-bit pattern: detect every cycle, count saturates at 255.
        do_cfg(16'b1, 5'd1, 1'b1, 1'b0, '0, '0, 1'b0, 0, "cfg_sat");
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, (i + 1 > 255) ? 255 : i + 1, $sformatf("sat_%0d", i));
        end

        // Length 0 disables matching regardless of data.
        do_cfg(16'h0000, 5'd0, 1'b1, 1'b0, '0, '0, 1'b0, 0, "cfg_len0");
        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 0, $sformatf("len0_%0d", i));
        end

        // Length 20 clamps to 16: detect exactly on the 16th bit.
        do_cfg(vec_big, 5'd20, 1'b1, 1'b0, '0, '0, 1'b0, 0, "cfg_len20");
        for (int i = 15; i >= 0; i--) begin
            step(vec_big[i], 1'b1, (i == 0), 1'b0, (i == 0) ? 1 : 0, $sformatf("clamp_bit%0d", 16 - i));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "clamp_idle");

        // Drain the scoreboard with a bounded wait.
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
